// File: rtl/fetch_unit.sv
// Instruction fetch front end. It has two pipeline slots: F2 holds the registered
// memory output and D holds the instruction handed to decode. A one-entry skid
// register keeps back-pressure from adding a bubble. It also handles branch
// redirects and a sticky HALT.
module fetch_unit #(
  parameter logic [9:0] RESET_PC    = 10'h000,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [9:0]  i_branch_target,
  input  logic [15:0] i_instr_mem_out,
  output logic [9:0]  o_prog_ctr,
  output logic [15:0] o_instr_out,
  output logic [9:0]  o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_halted
);

  // FILL: F2 empty; RUN: streaming; HALT: HALT word in D or fetch stopped
  typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_t;

  state_t      r_state;
  logic [9:0]  r_pc;
  logic [9:0]  r_f2_pc;
  logic        r_f2_valid;
  logic [15:0] r_skid_word;
  logic [9:0]  r_skid_pc;
  logic        r_skid_valid;
  logic [15:0] r_instr;
  logic [9:0]  r_instr_pc;
  logic        r_instr_valid;
  logic        r_halted;

  logic        w_ld_valid;
  logic [15:0] w_ld_word;
  logic [9:0]  w_ld_pc;
  logic        w_ld_halt;
  logic        w_ld_refetch;

  // Pick the word D would take on a free-running edge: the skid entry first, then F2
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_ld_valid   = 1'b0;
    w_ld_word    = i_instr_mem_out;
    w_ld_pc      = r_f2_pc;
    w_ld_halt    = 1'b0;
    w_ld_refetch = 1'b0;
    if (r_skid_valid) begin
      w_ld_valid = 1'b1;
      w_ld_word  = r_skid_word;
      w_ld_pc    = r_skid_pc;
    end else if (r_f2_valid) begin
      w_ld_valid = 1'b1;
    end
    w_ld_halt = w_ld_valid && (w_ld_word[15:12] == HALT_OPCODE);
    // A stall during FILL can leave F2 holding the word at the held prog_ctr.
    // Memory re-reads that same address on this edge. That copy is a duplicate
    // and must not be marked valid.
    w_ld_refetch = w_ld_valid && (w_ld_pc == r_pc);
  end

  // Fetch control and pipeline state: halt freeze, then branch, then stall, then advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_state       <= S_FILL;
      r_pc          <= RESET_PC;
      r_f2_pc       <= RESET_PC;
      r_f2_valid    <= 1'b0;
      // NOTE: the skid word and pc reset with everything else. They sit behind
      // r_skid_valid, but a reset value keeps them deterministic for debug.
      r_skid_word   <= 16'h0000;
      r_skid_pc     <= 10'h000;
      r_skid_valid  <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_pc    <= 10'h000;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else if (!r_halted) begin
      if (i_branch_taken) begin
        // Redirect wins over stall and over a pending HALT in D
        r_pc          <= i_branch_target;
        r_f2_valid    <= 1'b0;
        r_skid_valid  <= 1'b0;
        r_instr_valid <= 1'b0;
        r_state       <= S_FILL;
      end else if (i_stall) begin
        // D and prog_ctr hold; memory keeps returning the held address into F2
        r_f2_pc    <= r_pc;
        r_f2_valid <= 1'b1;
        if (r_f2_valid && !r_skid_valid) begin
          r_skid_word  <= i_instr_mem_out;
          r_skid_pc    <= r_f2_pc;
          r_skid_valid <= 1'b1;
        end
        if (r_state == S_FILL) begin
          r_state <= S_RUN;
        end
      end else if (r_state == S_HALT) begin
        // HALT has had its single accepted cycle in D; stop for good
        r_instr_valid <= 1'b0;
        r_halted      <= 1'b1;
      end else begin
        r_instr_valid <= w_ld_valid;
        if (w_ld_valid) begin
          r_instr    <= w_ld_word;
          r_instr_pc <= w_ld_pc;
        end
        r_skid_valid <= 1'b0;
        r_f2_pc      <= r_pc;
        r_f2_valid   <= !w_ld_refetch;
        r_pc         <= r_pc + 10'd1;
        if (w_ld_halt) begin
          r_state <= S_HALT;
        end else if (w_ld_refetch) begin
          r_state <= S_FILL;
        end else begin
          r_state <= S_RUN;
        end
      end
    end
  end

  assign o_prog_ctr    = r_pc;
  assign o_instr_out   = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. It runs directed scenarios for reset,
// stall, branch, HALT and wrap, then a randomized stall/branch run. The random
// run is checked against a sequential-stream reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic [15:0] mem_out;
  logic [15:0] mem_out2;
  logic [9:0]  prog_ctr, prog_ctr2;
  logic [15:0] instr_out, instr_out2;
  logic [9:0]  instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2;
  logic        halted, halted2;

  logic [15:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_instr_mem_out (mem_out),
    .o_prog_ctr      (prog_ctr),
    .o_instr_out     (instr_out),
    .o_instr_pc      (instr_pc),
    .o_instr_valid   (instr_valid),
    .o_halted        (halted)
  );

  // Second instance starts near the top of the address space to exercise the wrap
  fetch_unit #(.RESET_PC(10'h3FE)) u_dut_wrap (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_instr_mem_out (mem_out2),
    .o_prog_ctr      (prog_ctr2),
    .o_instr_out     (instr_out2),
    .o_instr_pc      (instr_pc2),
    .o_instr_valid   (instr_valid2),
    .o_halted        (halted2)
  );

  always #5 clk = ~clk;

  // Registered instruction memories: data for the address presented at the previous edge
  always @(posedge clk) begin
    mem_out  <= mem[prog_ctr];
    mem_out2 <= mem[prog_ctr2];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_pc(input string tag, input logic [9:0] pc, input int max_cycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (instr_valid && instr_pc == pc) found = 1'b1;
    end
    check(tag, {15'd0, found}, 16'd1);
  endtask

  logic [9:0]  exp_pc;
  logic [15:0] rnd_word;
  int          gap;
  logic        cur_stall, cur_branch;

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 10'h000;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

    // Reset state
    tick();
    tick();
    check("rst_prog_ctr", {6'd0, prog_ctr}, 16'h000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_instr_out", instr_out, 16'h0000);
    check("rst_instr_pc", {6'd0, instr_pc}, 16'h000);
    check("rst_wrap_prog_ctr", {6'd0, prog_ctr2}, 16'h3FE);

    // Start-up latency and sequential stream (plus wrap on the second instance)
    rst_n = 1'b1;
    tick();
    check("start_e1_valid", {15'd0, instr_valid}, 16'd0);
    check("start_e1_valid_wrap", {15'd0, instr_valid2}, 16'd0);
    tick();
    check("start_e2_valid", {15'd0, instr_valid}, 16'd1);
    check("start_e2_pc", {6'd0, instr_pc}, 16'h000);
    check("start_e2_word", instr_out, 16'h0000);
    check("wrap_pc0", {6'd0, instr_pc2}, 16'h3FE);
    tick();
    check("start_e3_pc", {6'd0, instr_pc}, 16'h001);
    check("wrap_pc1", {6'd0, instr_pc2}, 16'h3FF);
    tick();
    check("start_e4_pc", {6'd0, instr_pc}, 16'h002);
    check("wrap_pc2", {6'd0, instr_pc2}, 16'h000);
    check("wrap_word2", instr_out2, 16'h0000);
    tick();
    check("wrap_pc3", {6'd0, instr_pc2}, 16'h001);
    check("wrap_valid3", {15'd0, instr_valid2}, 16'd1);

    // Three-cycle stall while D holds 0x005
    wait_valid_pc("reach_005", 10'h005, 10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", {6'd0, instr_pc}, 16'h005);
      check("stall_hold_valid", {15'd0, instr_valid}, 16'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_rel_pc6", {6'd0, instr_pc}, 16'h006);
    check("stall_rel_valid6", {15'd0, instr_valid}, 16'd1);
    tick();
    check("stall_rel_pc7", {6'd0, instr_pc}, 16'h007);
    check("stall_rel_valid7", {15'd0, instr_valid}, 16'd1);

    // Branch to 0x120 while D holds 0x010
    wait_valid_pc("reach_010", 10'h010, 20);
    branch_taken = 1'b1;
    branch_target = 10'h120;
    tick();
    branch_taken = 1'b0;
    check("br_bubble1", {15'd0, instr_valid}, 16'd0);
    tick();
    check("br_bubble2", {15'd0, instr_valid}, 16'd0);
    tick();
    check("br_target_valid", {15'd0, instr_valid}, 16'd1);
    check("br_target_pc", {6'd0, instr_pc}, 16'h120);
    check("br_target_word", instr_out, 16'h0120);
    tick();
    check("br_next_pc", {6'd0, instr_pc}, 16'h121);

    // Branch and stall together: branch wins, skid is emptied
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 10'h200;
    tick();
    stall = 1'b0;
    branch_taken = 1'b0;
    check("brst_bubble1", {15'd0, instr_valid}, 16'd0);
    tick();
    check("brst_bubble2", {15'd0, instr_valid}, 16'd0);
    tick();
    check("brst_target_pc", {6'd0, instr_pc}, 16'h200);
    check("brst_target_valid", {15'd0, instr_valid}, 16'd1);
    tick();
    check("brst_next_pc", {6'd0, instr_pc}, 16'h201);

    // Asynchronous reset mid-stall discards in-flight words
    stall = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_prog_ctr", {6'd0, prog_ctr}, 16'h000);
    check("arst_valid", {15'd0, instr_valid}, 16'd0);
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_e1_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    check("arst_e2_pc", {6'd0, instr_pc}, 16'h000);
    check("arst_e2_valid", {15'd0, instr_valid}, 16'd1);

    // HALT at 0x008: one valid cycle, then frozen; branch ignored; reset clears
    mem[8] = 16'hF000;
    wait_valid_pc("reach_halt", 10'h008, 20);
    check("halt_word", instr_out, 16'hF000);
    check("halt_not_yet", {15'd0, halted}, 16'd0);
    tick();
    check("halt_valid_drop", {15'd0, instr_valid}, 16'd0);
    check("halt_set", {15'd0, halted}, 16'd1);
    check("halt_pc_frozen", {6'd0, prog_ctr}, 16'h00A);
    branch_taken = 1'b1;
    branch_target = 10'h050;
    tick();
    branch_taken = 1'b0;
    check("halt_br_ignored", {15'd0, halted}, 16'd1);
    check("halt_br_pc", {6'd0, prog_ctr}, 16'h00A);
    for (int i = 0; i < 3; i++) tick();
    check("halt_still_invalid", {15'd0, instr_valid}, 16'd0);
    check("halt_still_pc", {6'd0, prog_ctr}, 16'h00A);
    rst_n = 1'b0;
    #1;
    check("halt_rst_clear", {15'd0, halted}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("halt_restart_pc", {6'd0, instr_pc}, 16'h000);
    check("halt_restart_valid", {15'd0, instr_valid}, 16'd1);

    // HALT held by a stall, then cancelled by a branch
    wait_valid_pc("reach_halt2", 10'h008, 20);
    stall = 1'b1;
    tick();
    check("halt_stall_valid", {15'd0, instr_valid}, 16'd1);
    check("halt_stall_pc", {6'd0, instr_pc}, 16'h008);
    check("halt_stall_not_halted", {15'd0, halted}, 16'd0);
    stall = 1'b0;
    branch_taken = 1'b1;
    branch_target = 10'h040;
    tick();
    branch_taken = 1'b0;
    check("halt_cancel_halted", {15'd0, halted}, 16'd0);
    check("halt_cancel_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    tick();
    check("halt_cancel_target", {6'd0, instr_pc}, 16'h040);
    check("halt_cancel_still_run", {15'd0, halted}, 16'd0);

    // Randomized stall/branch run against a sequential-stream model
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) begin
      rnd_word = 16'($urandom);
      if (rnd_word[15:12] == 4'hF) rnd_word[15:12] = 4'h0;
      mem[i] = rnd_word;
    end
    tick();
    rst_n = 1'b1;
    exp_pc = 10'h000;
    gap = 0;
    cur_stall = 1'b0;
    cur_branch = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      // Liveness: without stall, a valid word must reappear within two edges
      if (cur_branch) gap = 1;
      else if (cur_stall) gap = 0;
      else if (instr_valid) gap = 0;
      else gap++;
      check("rnd_gap", {15'd0, (gap > 2)}, 16'd0);
      if (instr_valid) begin
        check("rnd_pc", {6'd0, instr_pc}, {6'd0, exp_pc});
        check("rnd_word", instr_out, mem[exp_pc]);
      end
      check("rnd_no_halt", {15'd0, halted}, 16'd0);
      cur_stall  = ($urandom_range(0, 99) < 30);
      cur_branch = ($urandom_range(0, 99) < 5);
      stall = cur_stall;
      branch_taken = cur_branch;
      branch_target = 10'($urandom_range(0, 1023));
      if (cur_branch) exp_pc = branch_target;
      else if (!cur_stall && instr_valid) exp_pc = exp_pc + 10'd1;
    end
    stall = 1'b0;
    branch_taken = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
